mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter sharing the single block-RAM port of the simple SoC between CPU instruction fetch (m0) and CPU data/load-store (m1). It sits between the CPU memory interface and the bus switch, serializes requests, and carries one transaction at a time. Each response is routed back to the requester that owns the transaction.

## Interface
- `XLEN`, 32: data width in bits.
- `ADDR_WIDTH`, 32: address width in bits.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `m0_valid` / `m1_valid` in 1: request pending.
- `m0_ready` / `m1_ready` out 1: request accepted this cycle.
- `m0_addr` / `m1_addr` in ADDR_WIDTH: byte address.
- `m0_wdata` / `m1_wdata` in XLEN: write data.
- `m0_wstrb` / `m1_wstrb` in XLEN/8: byte write enables; all zero means read.
- `m0_rvalid` / `m1_rvalid` out 1: one-cycle response pulse.
- `m0_rdata` / `m1_rdata` out XLEN: read data, valid with rvalid.
- `mem_valid` out 1: request to memory.
- `mem_ready` in 1: memory accepted the request.
- `mem_addr`, `mem_wdata`, `mem_wstrb` out: registered copy of the granted request.
- `mem_rvalid` in 1: response or write ack, exactly one per accepted request.
- `mem_rdata` in XLEN: read data.
- `grant` out 1: owner of the current or last transaction (0 = m0, 1 = m1).

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any valid is high, select a winner and assert only its `mN_ready` in that cycle (combinational from valid and arbitration state).
  - Latch addr/wdata/wstrb into registers, set `grant`, go to ISSUE.
  - If no valid is high, stay in IDLE.
- **ISSUE:**
  - `mem_valid`=1 with the latched fields.
  - When `mem_ready`=1, go to WAIT.
  - Fields are held stable while stalled.
- **WAIT:**
  - On `mem_rvalid`, pulse the owner's `mN_rvalid` for one cycle with `mN_rdata`=`mem_rdata`, then go to IDLE.
  - The non-owner's rvalid stays 0.
  - `mN_rdata` may follow `mem_rdata` unconditionally.
- A `mem_rvalid` arriving while in IDLE or ISSUE is ignored (protocol error; assertion in sim).
- Requesters must hold valid and fields until ready. Dropping valid before ready is legal and is never granted.
- Writes complete only on `mem_rvalid`, so m0 and m1 never overlap.

## Timing
- Reset: state=IDLE, `grant`=0, `mem_valid`=0, all `mN_ready`=0, all `mN_rvalid`=0, `mem_addr`/`mem_wdata`/`mem_wstrb`=0, last-winner pointer=1 (so m0 wins first under round-robin).
- Minimum transaction time with `mem_ready` tied high and rvalid the cycle after accept:
  - accept at cycle T (IDLE)
  - `mem_valid` at T+1
  - `mem_rvalid` at T+2
  - requester rvalid at T+2 (combinational pass-through of the pulse)
  - IDLE at T+3
  - next accept no earlier than T+3
- Simultaneous valids in IDLE: exactly one ready; the loser waits at least until the next IDLE.
- Reset asserted mid-transaction: immediate return to the reset values. The in-flight transaction is dropped and no rvalid is delivered.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous valids, the requester that did not win the previous grant wins.
  - The pointer updates on every accept.
- Not defined:
  - Fixed priority, m1 (data) always beats m0 (fetch).
  - The pointer register is removed.
  - m0 can starve while m1 requests back-to-back.

## Structure
- Shared package `mem_arb_pkg`: state enum `arb_state_t` {ARB_IDLE, ARB_ISSUE, ARB_WAIT}, and constants `ARB_M0`=1'b0, `ARB_M1`=1'b1.
- One sub-module, `mem_arb_pick`: combinational winner selection from (m0_valid, m1_valid, last) producing (any, winner). Its contents depend on `MEM_ARB_ROUND_ROBIN_EN`.

## Test plan
- m0 reads 0x0000_0F00 alone, memory returns 0xDEADBEEF one cycle after mem_ready → m0_rvalid 2 cycles after m0_ready, m0_rdata=0xDEADBEEF, m1_rvalid never high.
- m0 and m1 both valid from reset, round-robin on, each issues 4 requests → grants alternate m0,m1,m0,m1,... all responses to the correct owner. Fixed priority build → all 4 m1 grants before any m0 grant.
- m1 writes 0x12345678, strb 4'b1111, to 0x0F04 with mem_ready held low 5 cycles → mem_addr/mem_wdata stable throughout, m1_rvalid only after mem_rvalid, m0 request raised meanwhile not readied until IDLE.
- reset_n pulled low during WAIT → all outputs at reset values in the same cycle, no rvalid delivered afterwards, next grant goes to m0.
- m0_valid raised then dropped while m1 holds the port → m0 never readied, mem sees only m1 traffic.
- mem_rvalid injected in IDLE → ignored, no mN_rvalid, assertion flags an error.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and requester identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the two requesters; purely combinational, no state.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention, otherwise m1 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic m0_valid,
    input  logic m1_valid,
    input  logic last,
    output logic any,
    output logic winner
);

    assign any = m0_valid | m1_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the requester that did not win last time goes first.
    always_comb begin
        winner = ARB_M0;
        if (m0_valid && m1_valid) begin
            winner = ~last;
        end else if (m1_valid) begin
            winner = ARB_M1;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign winner      = m1_valid ? ARB_M1 : ARB_M0;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (m0) and load/store (m1), one transaction in flight.
// Latency: ready in the request cycle, mem_valid next cycle, response passes through the cycle it arrives.
// Backpressure: mem_ready stalls ISSUE with fields held; no new grant until the response. Option: MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [XLEN-1:0]       m0_wdata,
    input  logic [XLEN/8-1:0]     m0_wstrb,
    output logic                  m0_rvalid,
    output logic [XLEN-1:0]       m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [XLEN-1:0]       m1_wdata,
    input  logic [XLEN/8-1:0]     m1_wstrb,
    output logic                  m1_rvalid,
    output logic [XLEN-1:0]       m1_rdata,

    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [XLEN/8-1:0]     mem_wstrb,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,

    output logic                  grant
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       pick_any;
    logic       pick_winner;
    logic       last_winner;
    logic       accept;
    logic       proto_err;

    mem_arb_pick u_pick (
        .m0_valid (m0_valid),
        .m1_valid (m1_valid),
        .last     (last_winner),
        .any      (pick_any),
        .winner   (pick_winner)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Starts at m1 so that m0 wins the first contended grant after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner <= ARB_M1;
        end else if (accept) begin
            last_winner <= pick_winner;
        end
    end
`else
    assign last_winner = ARB_M1;
`endif

    // Ready is gated by reset so a held valid is never accepted while reset is low.
    assign accept = (state == ARB_IDLE) && pick_any && reset_n;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:  if (pick_any)   state_nxt = ARB_ISSUE;
            ARB_ISSUE: if (mem_ready)  state_nxt = ARB_WAIT;
            ARB_WAIT:  if (mem_rvalid) state_nxt = ARB_IDLE;
            default:                   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            grant     <= ARB_M0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant     <= pick_winner;
                mem_addr  <= (pick_winner == ARB_M1) ? m1_addr  : m0_addr;
                mem_wdata <= (pick_winner == ARB_M1) ? m1_wdata : m0_wdata;
                mem_wstrb <= (pick_winner == ARB_M1) ? m1_wstrb : m0_wstrb;
            end
        end
    end

    // Sticky flag: memory answered with no transaction waiting for a response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_err <= 1'b0;
        end else begin
            proto_err <= proto_err | (mem_rvalid && (state != ARB_WAIT));
        end
    end

    assign m0_ready  = accept && (pick_winner == ARB_M0);
    assign m1_ready  = accept && (pick_winner == ARB_M1);
    assign mem_valid = (state == ARB_ISSUE);
    assign m0_rvalid = (state == ARB_WAIT) && mem_rvalid && (grant == ARB_M0);
    assign m1_rvalid = (state == ARB_WAIT) && mem_rvalid && (grant == ARB_M1);
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule
